// File: rtl/out_port_fifo.sv
// Output-port controller for the datapath `out` instruction: captures bus writes
// into a show-ahead FIFO drained over valid/ready, with last-value and overflow status.
module out_port_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   clear,
  input  logic                   e_OutPort,
  input  logic [WIDTH-1:0]       BusMuxOut,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       last_out,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  input  logic                   ovf_clr
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wp_q, wp_d;
  logic [AW-1:0]    rp_q, rp_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] last_q, last_d;
  logic             ovf_q, ovf_d;
  logic             push, pop, drop;

  // Status is decoded from the occupancy register, never from pointer compare.
  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);
  assign out_valid = ~empty;
  assign out_data  = mem_q[rp_q];
  assign count     = count_q;
  assign last_out  = last_q;
  assign overflow  = ovf_q;

  // Handshake decode and next-state; a full FIFO still accepts when it pops.
  always_comb begin
    pop     = 1'b0;
    push    = 1'b0;
    drop    = 1'b0;
    wp_d    = wp_q;
    rp_d    = rp_q;
    count_d = count_q;
    last_d  = last_q;
    ovf_d   = ovf_q;

    pop  = out_valid & out_ready;
    push = e_OutPort & (~full | pop);
    drop = e_OutPort & full & ~pop;

    if (pop) begin
      rp_d = rp_q + AW'(1);
    end
    if (push) begin
      wp_d   = wp_q + AW'(1);
      last_d = BusMuxOut;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // A drop in the same cycle as a clear request keeps the flag set.
    if (drop) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
      last_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
      last_q  <= last_d;
      ovf_q   <= ovf_d;
    end
  end

  // Storage is reset so the show-ahead head is never X while empty.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push) begin
      mem_q[wp_q] <= BusMuxOut;
    end
  end

endmodule

// File: tb/tb_out_port_fifo.sv
// Bench for out_port_fifo: queue-based reference model checked every cycle,
// a vector table for fill/drain/overflow, and hand sequences for stream and reset.
module tb_out_port_fifo;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned DEPTH = 4;

  logic             clock = 1'b0;
  logic             clear;
  logic             e_OutPort;
  logic [WIDTH-1:0] BusMuxOut;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] last_out;
  logic             full;
  logic             empty;
  logic [2:0]       count;
  logic             overflow;
  logic             ovf_clr;

  out_port_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clock     (clock),
    .clear     (clear),
    .e_OutPort (e_OutPort),
    .BusMuxOut (BusMuxOut),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .last_out  (last_out),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .overflow  (overflow),
    .ovf_clr   (ovf_clr)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        e;
    logic [31:0] d;
    logic        rdy;
    logic        oc;
    int          cnt;
    logic        vld;
    logic [31:0] dat;
    logic [31:0] lst;
    logic        ovf;
  } vec_t;

  int          n_pass = 0;
  int          n_tot  = 0;
  logic [31:0] mq [$];
  logic [31:0] m_last = '0;
  logic        m_ovf  = 1'b0;
  vec_t        vq [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  function automatic vec_t mk(input logic e, input logic [31:0] d, input logic rdy,
                              input logic oc, input int cnt, input logic vld,
                              input logic [31:0] dat, input logic [31:0] lst, input logic ovf);
    vec_t v;
    v.e = e; v.d = d; v.rdy = rdy; v.oc = oc; v.cnt = cnt;
    v.vld = vld; v.dat = dat; v.lst = lst; v.ovf = ovf;
    return v;
  endfunction

  // Mid-cycle: compare DUT against the model, then advance the model to the next edge.
  task automatic tick();
    logic m_pop, m_push, m_drop, m_full;
    @(negedge clock);
    chk("m_valid", 32'(out_valid), 32'(mq.size() != 0));
    chk("m_count", 32'(count), 32'(mq.size()));
    chk("m_full", 32'(full), 32'(mq.size() == DEPTH));
    chk("m_empty", 32'(empty), 32'(mq.size() == 0));
    if (mq.size() != 0) chk("m_data", out_data, mq[0]);
    chk("m_last", last_out, m_last);
    chk("m_ovf", 32'(overflow), 32'(m_ovf));
    m_full = (mq.size() == DEPTH);
    m_pop  = (mq.size() != 0) && out_ready;
    m_push = e_OutPort && (!m_full || m_pop);
    m_drop = e_OutPort && m_full && !m_pop;
    if (m_pop) void'(mq.pop_front());
    if (m_push) begin
      mq.push_back(BusMuxOut);
      m_last = BusMuxOut;
    end
    if (m_drop) m_ovf = 1'b1;
    else if (ovf_clr) m_ovf = 1'b0;
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic e, input logic [31:0] d, input logic rdy, input logic oc);
    e_OutPort = e;
    BusMuxOut = d;
    out_ready = rdy;
    ovf_clr   = oc;
  endtask

  initial begin
    clear = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0);
    #3;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_data", out_data, 32'd0);
    chk("rst_last", last_out, 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    #9 clear = 1'b1;
    @(posedge clock);
    #1;

    // Single out
    vq.push_back(mk(1, 32'h77, 0, 0, 1, 1, 32'h77, 32'h77, 0));
    vq.push_back(mk(0, 32'h0,  1, 0, 0, 0, 32'h0,  32'h77, 0));
    // Fill, drop, drain, clear overflow
    vq.push_back(mk(1, 32'hA0, 0, 0, 1, 1, 32'hA0, 32'hA0, 0));
    vq.push_back(mk(1, 32'hA1, 0, 0, 2, 1, 32'hA0, 32'hA1, 0));
    vq.push_back(mk(1, 32'hA2, 0, 0, 3, 1, 32'hA0, 32'hA2, 0));
    vq.push_back(mk(1, 32'hA3, 0, 0, 4, 1, 32'hA0, 32'hA3, 0));
    vq.push_back(mk(1, 32'hA4, 0, 0, 4, 1, 32'hA0, 32'hA3, 1));
    vq.push_back(mk(0, 32'h0,  1, 0, 3, 1, 32'hA1, 32'hA3, 1));
    vq.push_back(mk(0, 32'h0,  1, 0, 2, 1, 32'hA2, 32'hA3, 1));
    vq.push_back(mk(0, 32'h0,  1, 0, 1, 1, 32'hA3, 32'hA3, 1));
    vq.push_back(mk(0, 32'h0,  1, 0, 0, 0, 32'h0,  32'hA3, 1));
    vq.push_back(mk(0, 32'h0,  0, 1, 0, 0, 32'h0,  32'hA3, 0));
    // Push while full with simultaneous pop
    vq.push_back(mk(1, 32'hA0, 0, 0, 1, 1, 32'hA0, 32'hA0, 0));
    vq.push_back(mk(1, 32'hA1, 0, 0, 2, 1, 32'hA0, 32'hA1, 0));
    vq.push_back(mk(1, 32'hA2, 0, 0, 3, 1, 32'hA0, 32'hA2, 0));
    vq.push_back(mk(1, 32'hA3, 0, 0, 4, 1, 32'hA0, 32'hA3, 0));
    vq.push_back(mk(1, 32'hB0, 1, 0, 4, 1, 32'hA1, 32'hB0, 0));
    vq.push_back(mk(0, 32'h0,  1, 0, 3, 1, 32'hA2, 32'hB0, 0));
    vq.push_back(mk(0, 32'h0,  1, 0, 2, 1, 32'hA3, 32'hB0, 0));
    vq.push_back(mk(0, 32'h0,  1, 0, 1, 1, 32'hB0, 32'hB0, 0));
    vq.push_back(mk(0, 32'h0,  1, 0, 0, 0, 32'h0,  32'hB0, 0));
    // Drop together with ovf_clr: set wins
    vq.push_back(mk(1, 32'hC0, 0, 0, 1, 1, 32'hC0, 32'hC0, 0));
    vq.push_back(mk(1, 32'hC1, 0, 0, 2, 1, 32'hC0, 32'hC1, 0));
    vq.push_back(mk(1, 32'hC2, 0, 0, 3, 1, 32'hC0, 32'hC2, 0));
    vq.push_back(mk(1, 32'hC3, 0, 0, 4, 1, 32'hC0, 32'hC3, 0));
    vq.push_back(mk(1, 32'hC4, 0, 1, 4, 1, 32'hC0, 32'hC3, 1));
    vq.push_back(mk(0, 32'h0,  0, 1, 4, 1, 32'hC0, 32'hC3, 0));
    vq.push_back(mk(0, 32'h0,  1, 0, 3, 1, 32'hC1, 32'hC3, 0));
    vq.push_back(mk(0, 32'h0,  1, 0, 2, 1, 32'hC2, 32'hC3, 0));
    vq.push_back(mk(0, 32'h0,  1, 0, 1, 1, 32'hC3, 32'hC3, 0));
    vq.push_back(mk(0, 32'h0,  1, 0, 0, 0, 32'h0,  32'hC3, 0));

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].e, vq[i].d, vq[i].rdy, vq[i].oc);
      tick();
      chk($sformatf("v%0d_count", i), 32'(count), 32'(vq[i].cnt));
      chk($sformatf("v%0d_valid", i), 32'(out_valid), 32'(vq[i].vld));
      if (vq[i].vld) chk($sformatf("v%0d_data", i), out_data, vq[i].dat);
      chk($sformatf("v%0d_last", i), last_out, vq[i].lst);
      chk($sformatf("v%0d_ovf", i), 32'(overflow), 32'(vq[i].ovf));
      chk($sformatf("v%0d_full", i), 32'(full), 32'(vq[i].cnt == DEPTH));
    end

    // Streaming with ready held high: one word per cycle, occupancy never above 1
    for (int i = 1; i <= 10; i++) begin
      drive(1'b1, 32'(i), 1'b1, 1'b0);
      tick();
      chk($sformatf("s%0d_data", i), out_data, 32'(i));
      chk($sformatf("s%0d_cnt_le1", i), 32'(count <= 3'd1), 32'd1);
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    tick();
    chk("s_end_empty", 32'(empty), 32'd1);

    // Reset mid-stream
    drive(1'b1, 32'h11, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h22, 1'b0, 1'b0);
    tick();
    drive(1'b0, '0, 1'b0, 1'b0);
    #1 clear = 1'b0;
    #1;
    chk("mrst_count", 32'(count), 32'd0);
    chk("mrst_valid", 32'(out_valid), 32'd0);
    chk("mrst_last", last_out, 32'd0);
    chk("mrst_ovf", 32'(overflow), 32'd0);
    chk("mrst_data", out_data, 32'd0);
    mq.delete();
    m_last = '0;
    m_ovf  = 1'b0;
    #1 clear = 1'b1;
    drive(1'b1, 32'h33, 1'b0, 1'b0);
    tick();
    chk("post_rst_data", out_data, 32'h33);
    chk("post_rst_count", 32'(count), 32'd1);
    drive(1'b0, '0, 1'b0, 1'b0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/out_port_fifo.md
# out_port_fifo

Output-port controller for the datapath's `out` instruction: the counterpart of the input port. When the control unit asserts `e_OutPort`, the value on the bus is captured into a small FIFO. The FIFO drains to an external consumer over a valid/ready handshake, which decouples the CPU from slow output devices. A legacy `last_out` register always shows the most recently accepted value, and status flags let the control unit stall or detect drops.

## Interface
- `WIDTH`, 32, data width of the bus and the port.
- `DEPTH`, 4, number of FIFO entries; must be a power of two and at least 2.
- `clock`  in  1  system clock; all state updates on the rising edge.
- `clear`  in  1  asynchronous, active-low reset (0 = reset).
- `e_OutPort`  in  1  write strobe from the control unit; samples `BusMuxOut` at the rising edge.
- `BusMuxOut`  in  WIDTH  datapath bus value.
- `out_data`  out  WIDTH  FIFO head (show-ahead); valid only while `out_valid` = 1.
- `out_valid`  out  1  FIFO not empty.
- `out_ready`  in  1  consumer accepts `out_data` this cycle.
- `last_out`  out  WIDTH  last value accepted into the FIFO.
- `full`  out  1  count == DEPTH.
- `empty`  out  1  count == 0.
- `count`  out  log2(DEPTH)+1  occupancy, 0..DEPTH.
- `overflow`  out  1  sticky flag: a write was dropped.
- `ovf_clr`  in  1  synchronous clear of `overflow`.

## Operation
- Storage:
  - DEPTH×WIDTH register array.
  - Write pointer `wp` and read pointer `rp`, each log2(DEPTH) bits; both wrap modulo DEPTH naturally.
  - Separate `count` register; `full` and `empty` are decoded from `count`, not from pointer comparison.
- Pop condition: `pop = out_valid & out_ready`. On a pop, `rp` increments.
- Push acceptance: `push = e_OutPort & (~full | pop)`.
  - A write while full is accepted only if a pop happens in the same cycle.
  - On a push: `mem[wp] <= BusMuxOut`, `wp` increments, and `last_out <= BusMuxOut`.
- Dropped write: `e_OutPort & full & ~pop`.
  - Data is discarded; `wp`, `count`, `mem` and `last_out` are unchanged.
  - `overflow` is set to 1.
- Count update:
  - +1 on push only.
  - −1 on pop only.
  - Unchanged on push and pop together, or on neither.
- Push and pop together when not full and not empty: both pointers advance and `count` holds.
- Push into an empty FIFO:
  - `out_valid` is 0 that cycle, so no pop is possible.
  - The new word appears on `out_data` with `out_valid` = 1 from the next cycle.
- `overflow` priority: set beats clear. A drop and `ovf_clr` in the same cycle leaves `overflow` = 1.
- `out_ready` while empty has no effect.
- `out_data` is `mem[rp]`, driven combinationally from registered state. Its value while empty is don't-care, but it must not be X after reset; reset `mem` to 0.
- Reset (`clear` = 0, asynchronous, takes effect mid-operation at any time):
  - `wp` = 0, `rp` = 0, `count` = 0, `mem` = 0.
  - `last_out` = 0, `overflow` = 0.
  - Therefore `out_valid` = 0, `empty` = 1, `full` = 0, `out_data` = 0.
  - Queued data is lost.
  - Release is synchronous to the next rising edge; the first push can be accepted on the first rising edge after `clear` goes high.

## Timing
- Write latency: `e_OutPort` sampled at edge N gives `out_valid` = 1 and head data visible after edge N, when the FIFO was empty.
- `last_out` updates after the same edge N.
- Handshake: a transfer occurs on each rising edge where `out_valid` & `out_ready` are both 1.
  - `out_data` advances to the next entry after that edge.
  - `out_valid` falls after the edge if that was the last entry.
- The consumer may hold `out_ready` high continuously, giving one word per cycle.
- While `out_valid` = 1 and no pop occurs, `out_data` is stable.
- `full`, `empty` and `count` are registered-derived and settle right after each edge. The control unit must sample `full` before issuing `e_OutPort` to avoid drops.
- All outputs are glitch-free relative to `clock`. There is no combinational path from `out_ready` to `out_data` or `out_valid`.

## Test plan
- Reset mid-stream: push 0x11 and 0x22, then pulse `clear` low between edges. Required immediately: `count` = 0, `out_valid` = 0, `last_out` = 0, `overflow` = 0. After release, push 0x33; `out_data` must be 0x33.
- Single out: with `out_ready` = 0, push 0x00000077. After the edge: `out_valid` = 1, `out_data` = 0x77, `last_out` = 0x77, `count` = 1. Raise `out_ready` for one cycle: `out_valid` = 0, `empty` = 1.
- Fill and overflow: push 0xA0, 0xA1, 0xA2, 0xA3, then 0xA4 with `out_ready` = 0.
  - Required: `full` = 1, `count` = 4, `overflow` = 1, `last_out` = 0xA3.
  - Drain order must be 0xA0, 0xA1, 0xA2, 0xA3; 0xA4 never appears.
- Push while full with pop: when full with head 0xA0, assert `e_OutPort` with 0xB0 and `out_ready` = 1 together.
  - `count` stays 4, `overflow` stays 0, `last_out` = 0xB0.
  - Drain yields 0xA1, 0xA2, 0xA3, 0xB0.
- Pointer wrap / streaming: hold `out_ready` = 1 and push 0x1..0xA on ten consecutive cycles. Every value must appear exactly once, in order, and `count` must never exceed 1.
- Overflow clear: with `overflow` = 1, pulse `ovf_clr` and `overflow` must go to 0. Pulse `ovf_clr` in the same cycle as a dropped write and `overflow` must stay 1.
